tlv5618_driver: RTL and testbench
=================================

# tlv5618_driver

Serial front-end for the TI TLV5618 dual 12-bit DAC. On a one-cycle start request it captures a 16-bit command word (4 control bits + 12 data bits, formatted upstream) and shifts it MSB-first over the 3-wire interface (CS_n, SCLK, DIN), then pulses a completion flag. It sits between the waveform/scope control logic and the DAC pins; it does not interpret the word.

## Interface
Parameters:
- WORD_W, 16, bits per frame.
- MIN_HALF, 2, minimum SCLK half-period in clk cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- div_parm  in  8  SCLK rate: half-period H = div_parm + MIN_HALF clk cycles; sampled at start.
- dac_data  in  16  frame to send; bit 15 first; sampled at start.
- en_conv  in  1  start strobe, one-cycle pulse; ignored while busy.
- conv_done  out  1  one-cycle pulse when the frame is complete and CS_n is high.
- dac_state  out  1  1 = busy (frame in progress), 0 = idle/ready.
- cs_n  out  1  DAC chip select, active low.
- sclk  out  1  serial clock; idles high.
- din  out  1  serial data to DAC.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE: cs_n=1, sclk=1, din=0, dac_state=0. On en_conv=1: latch dac_data into shift register, latch H from div_parm, go SETUP.
- SETUP (H cycles): cs_n=0, sclk=1, din=bit15, dac_state=1.
- SHIFT: 32 half-periods of H cycles each, starting with sclk falling. Each falling edge is the DAC sample point for the current bit; on each following rising edge, shift register advances and din presents the next bit. After the 16th falling edge (bit 0) and its low half-period, sclk returns high, go HOLD.
- HOLD (H cycles): cs_n=0, sclk=1, din holds bit 0.
- DONE (1 cycle): cs_n=1, conv_done=1, dac_state=0; next cycle IDLE. dac_state is 0 in DONE, so en_conv arriving in DONE is ignored; the next accepted start is on the first IDLE cycle.
- en_conv during SETUP/SHIFT/HOLD/DONE is dropped (no queuing). Changes to dac_data/div_parm after start have no effect on the current frame.
- Exactly 16 falling sclk edges per frame, all while cs_n=0; din stable for H cycles before and after each falling edge.

## Timing
- Reset: state IDLE; cs_n=1, sclk=1, din=0, conv_done=0, dac_state=0; shift register cleared. Reset mid-frame aborts immediately, with cs_n high the cycle after rst is sampled and no conv_done pulse.
- en_conv sampled high at edge 0 -> cs_n=0, dac_state=1 from cycle 1.
- cs_n low for 34·H cycles (SETUP H + SHIFT 32H + HOLD H); first sclk fall at cycle 1+H.
- conv_done high in cycle 1+34·H, simultaneously with cs_n=1.
- div_parm=0 -> H=2, SCLK = clk/4, conv_done at cycle 69. div_parm=255 -> H=257.
- Half-period counter width 9 bits (max H = 257); bit counter 5 bits.

## Structure
- Shared package tlv5618_pkg: state enum, WORD_W, MIN_HALF, bit-counter width.
- One sub-module, tlv5618_sclk_gen: loadable half-period counter emitting a one-cycle tick every H cycles while enabled. The top holds the FSM, shift register and output registers. All outputs are registered.

## Test plan
- Reset: hold rst 5 cycles -> cs_n=1, sclk=1, din=0, conv_done=0, dac_state=0.
- div_parm=0, dac_data=0xCAAA, pulse en_conv -> 16 falling sclk edges with din sampled = 1100_1010_1010_1010; cs_n low 68 cycles; conv_done single pulse at cycle 69.
- Then dac_data=0x4555 -> sampled 0100_0101_0101_0101, same timing; dac_state 1 for the whole frame.
- div_parm=3 (H=5), 0xFFFF -> sclk half-period 5 cycles, cs_n low 170 cycles, all bits 1.
- en_conv pulsed again mid-frame and dac_data changed to 0x0000 -> ignored; frame completes with the original word; one conv_done only.
- rst asserted after 8th falling edge -> cs_n and sclk high the next cycle, no conv_done; new en_conv afterwards sends a full 16-bit frame.

Source files
------------

// File: rtl/tlv5618_pkg.sv
// Shared definitions for the TLV5618 serial DAC driver.
// Holds the controller state encoding, frame/timing constants and the
// half-period helper used when a frame is started.
package tlv5618_pkg;

  localparam int DAC_WORD_W   = 16;
  localparam int DAC_MIN_HALF = 2;
  localparam int HALF_W       = 9;   // fits div_parm (255) + MIN_HALF = 257
  localparam int BIT_CNT_W    = 5;   // counts the 32 sclk half-periods of a frame

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_e;

  // SCLK half-period in clk cycles for a given rate setting.
  function automatic logic [HALF_W-1:0] half_period(input logic [7:0] div);
    return HALF_W'(div) + HALF_W'(DAC_MIN_HALF);
  endfunction

endpackage

// File: rtl/tlv5618_sclk_gen.sv
// Half-period timer for the TLV5618 driver.
// A down-counter loaded with the half-period H; while enabled it emits a
// one-cycle tick every H cycles and reloads itself from the captured H.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - capture period and restart the count (frame start)
//   period    - half-period H in clk cycles (>= 1)
//   en        - count enable
//   tick      - high in the last cycle of each half-period
module tlv5618_sclk_gen
  import tlv5618_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [HALF_W-1:0] period,
  input  logic              en,
  output logic              tick
);

  logic [HALF_W-1:0] period_q, period_d;
  logic [HALF_W-1:0] cnt_q, cnt_d;

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    if (load) begin
      period_d = period;
      cnt_d    = period - HALF_W'(1);
    end else if (en) begin
      if (cnt_q == '0) cnt_d = period_q - HALF_W'(1);
      else             cnt_d = cnt_q - HALF_W'(1);
    end
  end

  assign tick = en && !load && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/tlv5618_driver.sv
// 3-wire serial front-end for the TLV5618 dual 12-bit DAC.
// Captures a command word on en_conv and shifts it out MSB-first on din,
// framed by cs_n, with sclk idling high; pulses conv_done when finished.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   div_parm   - SCLK half-period = div_parm + MIN_HALF clk cycles
//   dac_data   - frame to send, MSB first
//   en_conv    - one-cycle start strobe, ignored unless idle
//   conv_done  - one-cycle completion pulse (cs_n already high)
//   dac_state  - 1 while a frame is in progress
//   cs_n, sclk, din - DAC serial pins (all registered)
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting for en_conv; pins idle
// ST_SETUP | cs_n low, sclk high, MSB on din for one half-period
// ST_SHIFT | 32 half-periods of sclk, falling edge first
// ST_HOLD  | sclk high, bit 0 held on din for one half-period
// ST_DONE  | cs_n high, conv_done pulse; back to idle
module tlv5618_driver
  import tlv5618_pkg::*;
#(
  parameter int WORD_W   = DAC_WORD_W,
  parameter int MIN_HALF = DAC_MIN_HALF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        div_parm,
  input  logic [WORD_W-1:0] dac_data,
  input  logic              en_conv,
  output logic              conv_done,
  output logic              dac_state,
  output logic              cs_n,
  output logic              sclk,
  output logic              din
);

  localparam logic [BIT_CNT_W-1:0] LAST_HALF = BIT_CNT_W'(2 * WORD_W - 1);
  // The last low half-period (bit 0): the rising edge after it must not shift.
  localparam logic [BIT_CNT_W-1:0] LAST_LOW  = BIT_CNT_W'(2 * WORD_W - 2);

  state_e                state_q, state_d;
  logic [WORD_W-1:0]     shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]  half_cnt_q, half_cnt_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  din_q, din_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic                  tmr_load;
  logic                  tmr_en;
  logic                  tick;
  logic [HALF_W-1:0]     start_half;

  // MIN_HALF is folded into the package helper; the parameter is kept for the
  // interface and must match DAC_MIN_HALF.
  assign start_half = half_period(div_parm);

  tlv5618_sclk_gen u_sclk_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .period (start_half),
    .en     (tmr_en),
    .tick   (tick)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    half_cnt_d = half_cnt_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    din_d      = din_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        din_d  = 1'b0;
        busy_d = 1'b0;
        if (en_conv) begin
          tmr_load   = 1'b1;
          shreg_d    = dac_data;
          din_d      = dac_data[WORD_W-1];
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          half_cnt_d = '0;
          state_d    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        tmr_en = 1'b1;
        if (tick) begin
          sclk_d  = 1'b0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        tmr_en = 1'b1;
        if (tick) begin
          half_cnt_d = half_cnt_q + BIT_CNT_W'(1);
          if (half_cnt_q == LAST_HALF) begin
            state_d = ST_HOLD;
          end else if (sclk_q) begin
            sclk_d = 1'b0;
          end else begin
            sclk_d = 1'b1;
            if (half_cnt_q != LAST_LOW) begin
              shreg_d = shreg_q << 1;
              din_d   = shreg_q[WORD_W-2];
            end
          end
        end
      end

      ST_HOLD: begin
        tmr_en = 1'b1;
        if (tick) begin
          cs_n_d  = 1'b1;
          din_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
        din_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      half_cnt_q <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b1;
      din_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      half_cnt_q <= half_cnt_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      din_q      <= din_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign conv_done = done_q;
  assign dac_state = busy_q;
  assign cs_n      = cs_n_q;
  assign sclk      = sclk_q;
  assign din       = din_q;

endmodule

// File: tb/tb_tlv5618_driver.sv
// Scoreboard bench for tlv5618_driver: the stimulus side pushes the frame it
// expects to see on the pins; a pin monitor decodes every cs_n-low window and
// compares it against the head of the queue when cs_n returns high.
module tb_tlv5618_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  div_parm;
  logic [15:0] dac_data;
  logic        en_conv;
  logic        conv_done, dac_state, cs_n, sclk, din;

  always #5 clk = ~clk;

  tlv5618_driver dut (
    .clk       (clk),
    .rst       (rst),
    .div_parm  (div_parm),
    .dac_data  (dac_data),
    .en_conv   (en_conv),
    .conv_done (conv_done),
    .dac_state (dac_state),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .din       (din)
  );

  typedef struct {
    bit          abort;
    logic [15:0] word;
    int          h;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // ---------------- monitor ----------------
  bit          in_frame = 0;
  int          low_cnt, falls, first_fall, run_len, run_min, run_max, din_bad;
  int          stray_done = 0, inv_bad = 0;
  logic [15:0] word;
  logic        prev_sclk, prev_din;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dac_state !== !cs_n) inv_bad++;
      if (cs_n === 1'b0) begin
        if (!in_frame) begin
          in_frame = 1; low_cnt = 1; falls = 0; first_fall = -1; word = '0;
          run_len = 1; run_min = 1 << 30; run_max = 0; din_bad = 0;
        end else begin
          low_cnt++;
          if (prev_sclk && !sclk) begin
            falls++;
            word = {word[14:0], din};
            if (falls == 1) first_fall = low_cnt - 1;
          end
          if (sclk == prev_sclk) run_len++;
          else begin
            if (run_len < run_min) run_min = run_len;
            if (run_len > run_max) run_max = run_len;
            run_len = 1;
          end
          if (din !== prev_din && !(sclk && !prev_sclk)) din_bad++;
        end
        if (conv_done === 1'b1) stray_done++;
      end else if (cs_n === 1'b1) begin
        if (in_frame) begin
          in_frame = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("conv_done_at_cs_rise", int'(conv_done), e.abort ? 0 : 1);
            check("sclk_high_at_cs_rise", int'(sclk), 1);
            if (e.abort) begin
              check("abort_falls", falls, 8);
            end else begin
              check("frame_word", int'(word), int'(e.word));
              check("frame_falls", falls, 16);
              check("cs_low_cycles", low_cnt, 34 * e.h);
              check("first_fall_offset", first_fall, e.h);
              check("sclk_run_min", run_min, e.h);
              check("sclk_run_max", run_max, e.h);
              check("final_high_run", run_len, 2 * e.h);
              check("din_stability", din_bad, 0);
            end
          end
        end else if (conv_done === 1'b1) begin
          stray_done++;
        end
      end
      prev_sclk = sclk;
      prev_din  = din;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input int h);
    int n;
    n = 0;
    while (conv_done !== 1'b1 && n < 34 * h + 50) begin
      @(negedge clk);
      n++;
    end
    if (conv_done !== 1'b1) check("conv_done_timeout", 0, 1);
  endtask

  // Called at a negedge in an idle cycle; returns at a negedge in an idle cycle.
  task automatic send(input logic [7:0] div, input logic [15:0] data,
                      input bit mid, input bit poke);
    exp_t e;
    int   h;
    h = int'(div) + 2;
    e.abort = 0; e.word = data; e.h = h;
    exp_q.push_back(e);
    div_parm = div; dac_data = data; en_conv = 1'b1;
    @(negedge clk);
    en_conv = 1'b0;
    check("start_cs_n", int'(cs_n), 0);
    check("start_busy", int'(dac_state), 1);
    dac_data = 16'($urandom_range(0, 65535));
    div_parm = 8'($urandom_range(0, 255));
    if (mid) begin
      repeat (5 * h) @(negedge clk);
      dac_data = 16'h0000;
      en_conv  = 1'b1;
      @(negedge clk);
      en_conv  = 1'b0;
      check("mid_en_busy", int'(dac_state), 1);
    end
    wait_done(h);
    if (poke) begin
      en_conv = 1'b1;
      @(negedge clk);
      en_conv = 1'b0;
      check("done_en_ignored_cs_n", int'(cs_n), 1);
      check("done_en_ignored_busy", int'(dac_state), 0);
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n, nf;
    logic ps;
    rst = 1'b1; en_conv = 1'b0; div_parm = '0; dac_data = '0;
    repeat (5) @(negedge clk);
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_sclk", int'(sclk), 1);
    check("rst_din", int'(din), 0);
    check("rst_conv_done", int'(conv_done), 0);
    check("rst_busy", int'(dac_state), 0);
    rst = 1'b0;
    @(negedge clk);

    send(8'd0, 16'hCAAA, 0, 0);
    send(8'd0, 16'h4555, 0, 1);
    send(8'd3, 16'hFFFF, 0, 0);
    send(8'd1, 16'h9C3B, 1, 0);

    // Abort after the 8th falling edge.
    e.abort = 1; e.word = 16'h0; e.h = 3;
    exp_q.push_back(e);
    div_parm = 8'd1; dac_data = 16'hA5F0; en_conv = 1'b1;
    @(negedge clk);
    en_conv = 1'b0;
    n = 0; nf = 0; ps = sclk;
    while (nf < 8 && n < 200) begin
      @(negedge clk);
      if (ps && !sclk) nf++;
      ps = sclk;
      n++;
    end
    check("abort_reached_8_falls", nf, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cs_n", int'(cs_n), 1);
    check("abort_sclk", int'(sclk), 1);
    check("abort_no_done", int'(conv_done), 0);
    @(negedge clk);

    send(8'd2, 16'h3C5A, 0, 0);
    send(8'd255, 16'($urandom_range(0, 65535)), 0, 0);
    for (int i = 0; i < 8; i++)
      send(8'($urandom_range(0, 6)), 16'($urandom_range(0, 65535)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("stray_conv_done", stray_done, 0);
    check("busy_matches_cs_n", inv_bad, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
